// File: rtl/gx_fifo_pkg.sv
// Shared definitions for the GX write-gather FIFO: write-size encodings,
// default geometry and the gather register layout.
package gx_fifo_pkg;

    localparam int DEFAULT_DEPTH_LOG2 = 5;
    localparam int DEPTH              = 1 << DEFAULT_DEPTH_LOG2;
    localparam int COUNT_W            = DEFAULT_DEPTH_LOG2 + 1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // bytes[3] is the first (most significant) gathered byte; unused lanes stay zero.
    typedef struct packed {
        logic [3:0][7:0] bytes;
        logic [1:0]      g;
    } gather_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/gx_fifo_gather.sv
// Big-endian byte-lane packer: appends incoming bytes behind the gathered ones
// and emits at most one completed 32-bit word per cycle.
module gx_fifo_gather
    import gx_fifo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_accept,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    input  logic        flush,
    output logic        push,
    output logic [31:0] push_word
);

    gather_t     cur;
    gather_t     nxt;
    logic [31:0] in_word;
    logic [63:0] combined;
    logic [3:0]  total;

    always_comb begin
        case (size)
            SIZE_BYTE: in_word = {data[7:0], 24'h0};
            SIZE_HALF: in_word = {data[15:0], 16'h0};
            SIZE_WORD: in_word = data;
            default:   in_word = '0;
        endcase
    end

    // Lanes past g are zero, so OR-ing the shifted write behind them concatenates the streams.
    assign combined = {cur.bytes, 32'h0} | ({in_word, 32'h0} >> {cur.g, 3'b000});
    assign total    = {2'b00, cur.g} + {1'b0, size_bytes(size)};

    always_comb begin
        nxt       = cur;
        push      = 1'b0;
        push_word = '0;
        if (wr_accept) begin
            if (total >= 4'd4) begin
                push      = 1'b1;
                push_word = combined[63:32];
                nxt.bytes = combined[31:0];
            end else begin
                nxt.bytes = combined[63:32];
            end
            nxt.g = total[1:0];
        end else if (flush && cur.g != 2'd0) begin
            push      = 1'b1;
            push_word = cur.bytes;
            nxt       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cur <= '0;
        else       cur <= nxt;
    end

endmodule

// File: rtl/gx_fifo.sv
// GX pipe write FIFO: gathers CPU writes into words, buffers them in a ring
// and presents them show-ahead to the command processor with watermark IRQs.
module gx_fifo
    import gx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WriteEn,
    input  logic [1:0]            WriteSize,
    input  logic [31:0]           WriteData,
    output logic                  WriteReady,
    input  logic                  Flush,
    input  logic                  GXFIFORead,
    output logic                  GXFIFOValid,
    output logic [31:0]           GXFIFOData,
    output logic [DEPTH_LOG2:0]   Count,
    input  logic [DEPTH_LOG2:0]   HiWatermark,
    input  logic [DEPTH_LOG2:0]   LoWatermark,
    input  logic                  HiEnable,
    input  logic                  LoEnable,
    output logic                  HiIRQ,
    output logic                  LoIRQ,
    output logic                  Overflow,
    input  logic                  OverflowClear
);

    localparam int RING = 1 << DEPTH_LOG2;

    logic [31:0]         mem [RING];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic                full;
    logic                accept;
    logic                drop;
    logic                flush_ok;
    logic                push;
    logic                pop;
    logic [31:0]         push_word;

    assign Count       = wptr - rptr;
    // Count never exceeds RING, so its MSB alone marks a full ring.
    assign full        = Count[DEPTH_LOG2];
    assign WriteReady  = !full;
    assign GXFIFOValid = Count != '0;
    assign GXFIFOData  = mem[rptr[DEPTH_LOG2-1:0]];

    assign accept   = WriteEn && !full && WriteSize != 2'd3;
    assign drop     = WriteEn && full;
    assign flush_ok = Flush && !WriteEn && !full;
    assign pop      = GXFIFORead && GXFIFOValid;

    gx_fifo_gather u_gather (
        .clk       (clk),
        .reset     (reset),
        .wr_accept (accept),
        .size      (WriteSize),
        .data      (WriteData),
        .flush     (flush_ok),
        .push      (push),
        .push_word (push_word)
    );

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wptr[DEPTH_LOG2-1:0]] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            Overflow <= 1'b0;
            HiIRQ    <= 1'b0;
            LoIRQ    <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (drop)               Overflow <= 1'b1;
            else if (OverflowClear) Overflow <= 1'b0;
            HiIRQ <= HiEnable && (Count >= HiWatermark);
            LoIRQ <= LoEnable && (Count <= LoWatermark);
        end
    end

endmodule

// File: tb/tb_gx_fifo.sv
// Self-checking bench for gx_fifo: directed scenarios plus a randomized run
// against a byte-queue / word-queue reference model.
module tb_gx_fifo;

    localparam int DL2 = 5;
    localparam int D   = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           WriteEn = 1'b0;
    logic [1:0]     WriteSize = 2'd0;
    logic [31:0]    WriteData = '0;
    logic           WriteReady;
    logic           Flush = 1'b0;
    logic           GXFIFORead = 1'b0;
    logic           GXFIFOValid;
    logic [31:0]    GXFIFOData;
    logic [DL2:0]   Count;
    logic [DL2:0]   HiWatermark = '0;
    logic [DL2:0]   LoWatermark = '0;
    logic           HiEnable = 1'b0;
    logic           LoEnable = 1'b0;
    logic           HiIRQ;
    logic           LoIRQ;
    logic           Overflow;
    logic           OverflowClear = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  gq[$];
    logic [31:0] fq[$];
    logic        m_ov = 1'b0;
    logic        m_hi = 1'b0;
    logic        m_lo = 1'b0;

    gx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .reset(reset), .WriteEn(WriteEn), .WriteSize(WriteSize),
        .WriteData(WriteData), .WriteReady(WriteReady), .Flush(Flush),
        .GXFIFORead(GXFIFORead), .GXFIFOValid(GXFIFOValid), .GXFIFOData(GXFIFOData),
        .Count(Count), .HiWatermark(HiWatermark), .LoWatermark(LoWatermark),
        .HiEnable(HiEnable), .LoEnable(LoEnable), .HiIRQ(HiIRQ), .LoIRQ(LoIRQ),
        .Overflow(Overflow), .OverflowClear(OverflowClear)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, clock, then return inputs to idle.
    task automatic tick(input logic rst, input logic we, input logic [1:0] sz,
                        input logic [31:0] d, input logic fl, input logic rd, input logic oc);
        int cnt;
        int s;
        logic [31:0] w;
        logic hi_n, lo_n, set_ov;
        cnt  = fq.size();
        hi_n = HiEnable && (cnt >= int'(HiWatermark));
        lo_n = LoEnable && (cnt <= int'(LoWatermark));
        reset = rst; WriteEn = we; WriteSize = sz; WriteData = d;
        Flush = fl; GXFIFORead = rd; OverflowClear = oc;
        if (rst) begin
            gq.delete(); fq.delete();
            m_ov = 1'b0; m_hi = 1'b0; m_lo = 1'b0;
        end else begin
            if (rd && cnt != 0) void'(fq.pop_front());
            set_ov = we && cnt >= D;
            if (we && cnt < D && sz != 2'd3) begin
                s = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                for (int k = s - 1; k >= 0; k--) gq.push_back(d[8*k +: 8]);
                if (gq.size() >= 4) begin
                    w = {gq[0], gq[1], gq[2], gq[3]};
                    repeat (4) void'(gq.pop_front());
                    fq.push_back(w);
                end
            end else if (!we && fl && cnt < D && gq.size() != 0) begin
                w = '0;
                for (int k = 0; k < gq.size(); k++) w[31-8*k -: 8] = gq[k];
                gq.delete();
                fq.push_back(w);
            end
            if (set_ov) m_ov = 1'b1;
            else if (oc) m_ov = 1'b0;
            m_hi = hi_n;
            m_lo = lo_n;
        end
        @(posedge clk);
        #1;
        reset = 1'b0; WriteEn = 1'b0; WriteSize = 2'd0; WriteData = '0;
        Flush = 1'b0; GXFIFORead = 1'b0; OverflowClear = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sz, input logic [31:0] d);
        tick(1'b0, 1'b1, sz, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_one();
        tick(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        LoEnable = 1'b1; LoWatermark = '0;
        tick(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Count); end
        checks++; if (GXFIFOValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", GXFIFOValid); end
        checks++; if (WriteReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", WriteReady); end
        checks++; if ({Overflow, HiIRQ, LoIRQ} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {Overflow, HiIRQ, LoIRQ}); end
        idle();
        checks++; if (LoIRQ !== 1'b1) begin errors++; $display("FAIL reset_lo_rise got %b want 1", LoIRQ); end
        LoEnable = 1'b0;
        idle();
        checks++; if (LoIRQ !== 1'b0) begin errors++; $display("FAIL lo_disable got %b want 0", LoIRQ); end
    endtask

    task automatic test_byte_gather();
        wr(2'd0, 32'h11); wr(2'd0, 32'hFF22); wr(2'd0, 32'h33);
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL gather_partial_count got %0d want 0", Count); end
        wr(2'd0, 32'h44);
        checks++; if (Count !== 6'd1 || GXFIFOValid !== 1'b1) begin errors++; $display("FAIL gather_count got %0d/%b want 1/1", Count, GXFIFOValid); end
        checks++; if (GXFIFOData !== 32'h11223344) begin errors++; $display("FAIL gather_data got %h want 11223344", GXFIFOData); end
        rd_one();
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL gather_pop got %0d want 0", Count); end
    endtask

    task automatic test_mixed_flush();
        wr(2'd0, 32'hAA); wr(2'd0, 32'hBB); wr(2'd0, 32'hCC); wr(2'd1, 32'h1234DDEE);
        checks++; if (Count !== 6'd1 || GXFIFOData !== 32'hAABBCCDD) begin errors++; $display("FAIL mixed_word got %0d/%h want 1/aabbccdd", Count, GXFIFOData); end
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 6'd2) begin errors++; $display("FAIL flush_count got %0d want 2", Count); end
        rd_one();
        checks++; if (GXFIFOData !== 32'hEE000000) begin errors++; $display("FAIL flush_data got %h want ee000000", GXFIFOData); end
        // Flush with nothing gathered must not push
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL flush_empty got %0d want 0", Count); end
        // Flush with a concurrent write: write wins, flush ignored
        wr(2'd0, 32'h01);
        tick(1'b0, 1'b1, 2'd0, 32'h02, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL flush_with_write got %0d want 0", Count); end
        wr(2'd1, 32'h0304);
        checks++; if (GXFIFOData !== 32'h01020304) begin errors++; $display("FAIL flush_with_write_data got %h want 01020304", GXFIFOData); end
        rd_one();
    endtask

    task automatic test_full_overflow();
        int bad;
        logic [31:0] exp;
        for (int i = 0; i < 31; i++) wr(2'd2, 32'h1000 + i);
        wr(2'd0, 32'h5A);
        wr(2'd2, 32'hCAFEBABE);
        checks++; if (Count !== 6'd32 || WriteReady !== 1'b0) begin errors++; $display("FAIL full_state got %0d/%b want 32/0", Count, WriteReady); end
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 6'd32 || Overflow !== 1'b0) begin errors++; $display("FAIL flush_full got %0d/%b want 32/0", Count, Overflow); end
        wr(2'd2, 32'hDEADBEEF);
        checks++; if (Overflow !== 1'b1 || Count !== 6'd32) begin errors++; $display("FAIL overflow_set got %b/%0d want 1/32", Overflow, Count); end
        tick(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", Overflow); end
        tick(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL overflow_set_wins got %b want 1", Overflow); end
        tick(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1);
        checks++; if (Count !== 6'd31 || WriteReady !== 1'b1) begin errors++; $display("FAIL full_pop got %0d/%b want 31/1", Count, WriteReady); end
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 6'd32) begin errors++; $display("FAIL flush_retained got %0d want 32", Count); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            exp = (i < 30) ? 32'h1001 + i : (i == 30) ? 32'h5ACAFEBA : 32'hBE000000;
            if (GXFIFOData !== exp && bad == 0) bad = i + 1;
            rd_one();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_drain first bad index got %0d want 0", bad); end
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL full_drain_count got %0d want 0", Count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v[5];
        tick(1'b0, 1'b1, 2'd2, 32'h600DF00D, 1'b0, 1'b1, 1'b0);
        checks++; if (Count !== 6'd1) begin errors++; $display("FAIL push_empty_pop got %0d want 1", Count); end
        rd_one();
        for (int i = 0; i < 5; i++) begin v[i] = $urandom; wr(2'd2, v[i]); end
        checks++; if (Count !== 6'd5) begin errors++; $display("FAIL b2b_fill got %0d want 5", Count); end
        tick(1'b0, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
        checks++; if (Count !== 6'd5) begin errors++; $display("FAIL b2b_count got %0d want 5", Count); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (GXFIFOData !== v[i]) begin errors++; $display("FAIL b2b_order got %h want %h", GXFIFOData, v[i]); end
            rd_one();
        end
        checks++; if (GXFIFOData !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_fifth got %h want cafef00d", GXFIFOData); end
        rd_one();
    endtask

    task automatic test_watermarks();
        HiWatermark = 6'd4; HiEnable = 1'b1;
        for (int i = 0; i < 4; i++) wr(2'd2, 32'hA0 + i);
        checks++; if (Count !== 6'd4 || HiIRQ !== 1'b0) begin errors++; $display("FAIL hi_lag got %0d/%b want 4/0", Count, HiIRQ); end
        idle();
        checks++; if (HiIRQ !== 1'b1) begin errors++; $display("FAIL hi_rise got %b want 1", HiIRQ); end
        rd_one();
        checks++; if (Count !== 6'd3 || HiIRQ !== 1'b1) begin errors++; $display("FAIL hi_fall_lag got %0d/%b want 3/1", Count, HiIRQ); end
        idle();
        checks++; if (HiIRQ !== 1'b0) begin errors++; $display("FAIL hi_fall got %b want 0", HiIRQ); end
        LoWatermark = 6'd3; LoEnable = 1'b1;
        idle();
        checks++; if (LoIRQ !== 1'b1) begin errors++; $display("FAIL lo_rise got %b want 1", LoIRQ); end
        HiEnable = 1'b0; LoEnable = 1'b0;
        repeat (3) rd_one();
    endtask

    task automatic test_reset_mid_gather();
        for (int i = 0; i < 3; i++) wr(2'd2, 32'h0);
        wr(2'd0, 32'h77); wr(2'd0, 32'h88);
        wr(2'd2, 32'h0); wr(2'd2, 32'h0);
        tick(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) wr(2'd2, 32'h0);
        wr(2'd2, 32'h0);
        tick(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (Count !== 6'd0 || GXFIFOValid !== 1'b0 || Overflow !== 1'b0) begin errors++; $display("FAIL midreset got %0d/%b/%b want 0/0/0", Count, GXFIFOValid, Overflow); end
        wr(2'd0, 32'h01); wr(2'd0, 32'h02); wr(2'd0, 32'h03); wr(2'd0, 32'h04);
        checks++; if (Count !== 6'd1 || GXFIFOData !== 32'h01020304) begin errors++; $display("FAIL midreset_fresh got %0d/%h want 1/01020304", Count, GXFIFOData); end
    endtask

    task automatic test_random();
        int rd_pct;
        tick(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        for (int ph = 0; ph < 6; ph++) begin
            rd_pct      = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 45 : 75;
            HiWatermark = 6'($urandom_range(0, 32));
            LoWatermark = 6'($urandom_range(0, 32));
            HiEnable    = 1'($urandom_range(0, 1));
            LoEnable    = 1'($urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                tick(1'b0, $urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), $urandom,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < rd_pct,
                     $urandom_range(0, 99) < 5);
                checks++; if (int'(Count) != fq.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", Count, fq.size()); end
                checks++; if (GXFIFOValid !== (fq.size() != 0)) begin errors++; $display("FAIL rnd_valid got %b want %b", GXFIFOValid, fq.size() != 0); end
                if (fq.size() != 0) begin
                    checks++; if (GXFIFOData !== fq[0]) begin errors++; $display("FAIL rnd_data got %h want %h", GXFIFOData, fq[0]); end
                end
                checks++; if (WriteReady !== (fq.size() < D)) begin errors++; $display("FAIL rnd_ready got %b want %b", WriteReady, fq.size() < D); end
                checks++; if (Overflow !== m_ov) begin errors++; $display("FAIL rnd_overflow got %b want %b", Overflow, m_ov); end
                checks++; if ({HiIRQ, LoIRQ} !== {m_hi, m_lo}) begin errors++; $display("FAIL rnd_irq got %b want %b", {HiIRQ, LoIRQ}, {m_hi, m_lo}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_gather();
        test_mixed_flush();
        test_full_overflow();
        test_back_to_back();
        test_watermarks();
        test_reset_mid_gather();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gx_fifo.md
Name: gx_fifo

Overview:
Buffers CPU writes to the GX pipe before the command processor reads them.
- Accepts 8-, 16- and 32-bit CPU writes and gathers them, big-endian, into 32-bit words.
- Stores the words in a ring buffer and presents them on a show-ahead Read/Valid interface.
- Drives the command processor's GXFIFORead/GXFIFOValid/GXFIFOData inputs.
- Raises high/low watermark interrupts and a sticky overflow flag.

Parameters:
DEPTH_LOG2, 5, log2 of buffer depth in words (DEPTH = 32).

Ports:
clk  in  1  sole clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
WriteEn  in  1  CPU write strobe, one write per cycle.
WriteSize  in  2  write size: 0 = byte, 1 = half, 2 = word; 3 is reserved and the write is ignored.
WriteData  in  32  write data, right-justified: byte in [7:0], half in [15:0].
WriteReady  out  1  high when Count < DEPTH.
Flush  in  1  push the partial gather word, zero-padded.
GXFIFORead  in  1  pop strobe from the command processor.
GXFIFOValid  out  1  high when Count != 0.
GXFIFOData  out  32  word at the read pointer; valid while GXFIFOValid is high.
Count  out  DEPTH_LOG2+1  words currently stored.
HiWatermark  in  DEPTH_LOG2+1  high-watermark threshold.
LoWatermark  in  DEPTH_LOG2+1  low-watermark threshold.
HiEnable  in  1  enables HiIRQ.
LoEnable  in  1  enables LoIRQ.
HiIRQ  out  1  registered: HiEnable && Count >= HiWatermark.
LoIRQ  out  1  registered: LoEnable && Count <= LoWatermark.
Overflow  out  1  sticky; set by a dropped write.
OverflowClear  in  1  clears Overflow.

Behaviour:
- Reset: read and write pointers = 0; gather byte count g = 0; gather register = 0; Overflow, HiIRQ, LoIRQ = 0.
  - GXFIFOValid = 0 and Count = 0 in the cycle after reset.
  - Reset mid-gather discards all partial bytes.
- Storage: DEPTH x 32 memory; pointers carry DEPTH_LOG2+1 bits; Count = wptr - rptr, modulo 2^(DEPTH_LOG2+1).
  - Pointers wrap naturally at DEPTH.
- Gather: a write is accepted when WriteEn && WriteReady && WriteSize != 3; s = 1, 2 or 4 bytes.
  - If g + s < 4: the incoming bytes are appended most-significant-first; g <= g + s.
  - If g + s >= 4: push word = {g gathered bytes, first 4-g incoming bytes}. The remaining g+s-4 bytes (0..3) become the new gather contents.
  - Example: g = 3 plus a half-word completes one word and leaves one byte.
  - Any accepted write pushes at most one word.
- Push timing: memory is written on the accepting edge. Count and GXFIFOValid reflect the push in the following cycle.
- Drop: WriteEn && !WriteReady → the write is discarded; gather state is unchanged; Overflow <= 1.
- Overflow: OverflowClear clears it. If set and clear occur in the same cycle, set wins.
- Pop: GXFIFORead && GXFIFOValid → rptr++. GXFIFORead while !GXFIFOValid is ignored.
  - GXFIFOData is a combinational read of mem[rptr[DEPTH_LOG2-1:0]].
- Simultaneous push and pop: both occur; Count is unchanged. A push into an empty buffer is not visible to a pop in the same cycle.
- Flush with 0 < g < 4 and Count < DEPTH: pushes {gathered bytes, zero padding}; g <= 0.
  - Flush with g = 0: no-op.
  - Flush when full: ignored and g is retained; Overflow is not set.
  - Flush together with WriteEn in the same cycle: the write is processed and the Flush is ignored.
- IRQs: registered from the current Count, so they lag Count by one cycle. With LoEnable set, LoIRQ rises the second cycle after reset (Count 0 <= LoWatermark).

Decomposition:
- Package gx_fifo_pkg holds:
  - size encodings SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2;
  - localparams DEPTH and COUNT_W derived from DEPTH_LOG2;
  - a gather-state typedef (4 x 8-bit bytes plus 2-bit g).
- One sub-module, gx_fifo_gather: byte-lane packer.
  - Inputs: accepted write, size, data, flush.
  - Outputs: push strobe and push word.
  - Holds the gather register.
- The top level contains the ring buffer, pointers, flags and IRQs.

Test Plan:
- Byte writes 0x11, 0x22, 0x33, 0x44 → one push of 0x11223344; GXFIFOValid = 1 and Count = 1 the cycle after the 4th write.
- Bytes 0xAA, 0xBB, 0xCC, then half 0xDDEE → pushes 0xAABBCCDD with g = 1 remaining; then Flush → pushes 0xEE000000; Count = 2; reads return the words in that order.
- 32 word writes with no reads → WriteReady = 0 at Count = 32; a 33rd word write is dropped and Overflow = 1; OverflowClear → Overflow = 0; a read then sets WriteReady = 1 next cycle.
- Count = 5; GXFIFORead plus a word write of 0xCAFEF00D in the same cycle → Count stays 5; 0xCAFEF00D is read out 5th from that point.
- HiWatermark = 4, HiEnable = 1; 4 word pushes → HiIRQ = 1 the cycle after Count = 4; one pop → HiIRQ = 0 one cycle after Count = 3. Then LoWatermark = 3 with LoEnable set → LoIRQ = 1.
- Count = 3 and g = 2, then reset for one cycle → Count = 0, GXFIFOValid = 0, Overflow = 0; the next 4 byte writes form a fresh word with no stale bytes.
